// File: rtl/ibex_bp_pkg.sv
// Shared types and constants for the fetch-stage branch-prediction controller.
package ibex_bp_pkg;

  // Instruction lengths in bytes, used to form the fall-through PC.
  localparam int unsigned BP_ILEN_C = 2;
  localparam int unsigned BP_ILEN_I = 4;

  // One outstanding prediction as recorded at push time.
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] fallthrough;
  } bp_entry_t;

  typedef enum logic [0:0] {
    BP_RUN   = 1'b0,
    BP_FLUSH = 1'b1
  } bp_state_e;

endpackage

// File: rtl/ibex_bp_fifo.sv
// Synchronous FIFO with push/pop/clear, occupancy count and full/empty flags.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
module ibex_bp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Occupancy update; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers; clear wins over push/pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ibex_bp_ctrl.sv
// Static branch-predictor sequencing controller: queues IF predictions in
// order, checks each against the EX resolution, and on a mispredict issues
// a one-cycle redirect then blocks predictions until IF acknowledges a flush.
// Optional saturating performance counters are enabled by IBEX_BP_PERF_EN.
module ibex_bp_ctrl
  import ibex_bp_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PerfCntW = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pred_valid_i,
  output logic                pred_ready_o,
  input  logic                pred_taken_i,
  input  logic [31:0]         pred_target_i,
  input  logic [31:0]         pred_pc_i,
  input  logic                pred_compressed_i,
  input  logic                resolve_valid_i,
  input  logic                resolve_taken_i,
  input  logic [31:0]         resolve_target_i,
  output logic                redirect_o,
  output logic [31:0]         redirect_pc_o,
  input  logic                flush_ack_i,
  output logic                busy_o,
`ifdef IBEX_BP_PERF_EN
  output logic [PerfCntW-1:0] perf_resolved_o,
  output logic [PerfCntW-1:0] perf_mispredict_o,
`endif
  output logic                err_o
);

  bp_state_e             state_q, state_d;
  logic                  redirect_q;
  logic [31:0]           redirect_pc_q, redirect_pc_d;
  logic                  err_q;

  bp_entry_t             push_entry, head;
  logic [$clog2(DEPTH):0] count;
  logic                  full, empty;
  logic                  push, resolve_act, pop, mispredict, err_set;

  assign push_entry.taken       = pred_taken_i;
  assign push_entry.target      = pred_target_i;
  assign push_entry.fallthrough = pred_pc_i +
      (pred_compressed_i ? 32'(BP_ILEN_C) : 32'(BP_ILEN_I));

  assign pred_ready_o = (state_q == BP_RUN) & ~full;
  assign push         = pred_valid_i & pred_ready_o;
  assign resolve_act  = resolve_valid_i & (state_q == BP_RUN);
  assign pop          = resolve_act & ~empty;
  assign err_set      = resolve_act & empty;
  assign mispredict   = pop & ((resolve_taken_i != head.taken) |
                               (resolve_taken_i & head.taken &
                                (resolve_target_i != head.target)));
  assign redirect_pc_d = resolve_taken_i ? resolve_target_i : head.fallthrough;

  // A mispredict clears the whole queue and discards a same-cycle push.
  ibex_bp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(bp_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (mispredict),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // RUN/FLUSH sequencing; an ack arriving with the redirect pulse is too early.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BP_RUN:   if (mispredict) state_d = BP_FLUSH;
      BP_FLUSH: if (flush_ack_i && !redirect_q) state_d = BP_RUN;
      default:  state_d = BP_RUN;
    endcase
  end

  // State, redirect pulse/PC and sticky error registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= BP_RUN;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      redirect_q <= mispredict;
      if (mispredict) redirect_pc_q <= redirect_pc_d;
      if (err_set)    err_q         <= 1'b1;
    end
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign err_o         = err_q;
  assign busy_o        = (count != '0) | (state_q == BP_FLUSH);

`ifdef IBEX_BP_PERF_EN
  logic [PerfCntW-1:0] perf_res_q, perf_mis_q;

  // Saturating counters of resolved and mispredicted pops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_res_q <= '0;
      perf_mis_q <= '0;
    end else begin
      if (pop && (perf_res_q != '1))        perf_res_q <= perf_res_q + PerfCntW'(1);
      if (mispredict && (perf_mis_q != '1)) perf_mis_q <= perf_mis_q + PerfCntW'(1);
    end
  end

  assign perf_resolved_o   = perf_res_q;
  assign perf_mispredict_o = perf_mis_q;
`endif

endmodule

// File: tb/tb_ibex_bp_ctrl.sv
// Directed self-checking bench for ibex_bp_ctrl (DEPTH=4). Perf-counter
// checks are compiled in when IBEX_BP_PERF_EN is defined.
module tb_ibex_bp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken, pred_compressed;
  logic [31:0] pred_target, pred_pc;
  logic        resolve_valid, resolve_taken;
  logic [31:0] resolve_target;
  logic        flush_ack;
  logic        pred_ready, redirect, busy, err;
  logic [31:0] redirect_pc;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  always #5 clk = ~clk;

`ifdef IBEX_BP_PERF_EN
  logic [31:0] perf_res, perf_mis;
  logic [1:0]  perf2_res, perf2_mis;
  logic        d2_ready, d2_redirect, d2_busy, d2_err;
  logic [31:0] d2_redirect_pc;
`endif

  ibex_bp_ctrl #(.DEPTH(4), .PerfCntW(32)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .pred_valid_i      (pred_valid),
    .pred_ready_o      (pred_ready),
    .pred_taken_i      (pred_taken),
    .pred_target_i     (pred_target),
    .pred_pc_i         (pred_pc),
    .pred_compressed_i (pred_compressed),
    .resolve_valid_i   (resolve_valid),
    .resolve_taken_i   (resolve_taken),
    .resolve_target_i  (resolve_target),
    .redirect_o        (redirect),
    .redirect_pc_o     (redirect_pc),
    .flush_ack_i       (flush_ack),
    .busy_o            (busy),
`ifdef IBEX_BP_PERF_EN
    .perf_resolved_o   (perf_res),
    .perf_mispredict_o (perf_mis),
`endif
    .err_o             (err)
  );

`ifdef IBEX_BP_PERF_EN
  ibex_bp_ctrl #(.DEPTH(4), .PerfCntW(2)) dut2 (
    .clk_i             (clk),
    .rst_i             (rst),
    .pred_valid_i      (pred_valid),
    .pred_ready_o      (d2_ready),
    .pred_taken_i      (pred_taken),
    .pred_target_i     (pred_target),
    .pred_pc_i         (pred_pc),
    .pred_compressed_i (pred_compressed),
    .resolve_valid_i   (resolve_valid),
    .resolve_taken_i   (resolve_taken),
    .resolve_target_i  (resolve_target),
    .redirect_o        (d2_redirect),
    .redirect_pc_o     (d2_redirect_pc),
    .flush_ack_i       (flush_ack),
    .busy_o            (d2_busy),
    .perf_resolved_o   (perf2_res),
    .perf_mispredict_o (perf2_mis),
    .err_o             (d2_err)
  );
`endif

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Push one prediction, then resolve it on the following cycle.
  task automatic do_pair(input logic pt, input logic [31:0] ptgt, input logic [31:0] pc,
                         input logic comp, input logic rt, input logic [31:0] rtgt);
    pred_valid = 1'b1; pred_taken = pt; pred_target = ptgt; pred_pc = pc; pred_compressed = comp;
    cyc();
    pred_valid = 1'b0;
    resolve_valid = 1'b1; resolve_taken = rt; resolve_target = rtgt;
    cyc();
    resolve_valid = 1'b0;
  endtask

  // Acknowledge a flush after the redirect pulse has passed.
  task automatic ack();
    flush_ack = 1'b1;
    cyc();
    cyc();
    flush_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pred_valid = 1'b0; pred_taken = 1'b0; pred_compressed = 1'b0;
    pred_target = '0; pred_pc = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
    flush_ack = 1'b0;
    #1;
    chk1 ("rst_redirect", redirect, 1'b0);
    chk32("rst_redirect_pc", redirect_pc, 32'h0);
    chk1 ("rst_err", err, 1'b0);
    chk1 ("rst_busy", busy, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;
    chk1 ("rst_ready", pred_ready, 1'b1);

    // Correctly predicted taken branch
    pred_valid = 1'b1; pred_taken = 1'b1; pred_target = 32'h100; pred_pc = 32'h80; pred_compressed = 1'b0;
    cyc();
    pred_valid = 1'b0;
    chk1 ("push_busy", busy, 1'b1);
    resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h100;
    cyc();
    resolve_valid = 1'b0;
    chk1 ("correct_no_redirect", redirect, 1'b0);
    chk1 ("correct_idle", busy, 1'b0);

    // Predicted not-taken, actually taken
    do_pair(1'b0, 32'h0, 32'h200, 1'b1, 1'b1, 32'h400);
    chk1 ("nt_t_redirect", redirect, 1'b1);
    chk32("nt_t_pc", redirect_pc, 32'h400);
    chk1 ("flush_ready", pred_ready, 1'b0);
    flush_ack = 1'b1;
    cyc();
    chk1 ("redirect_one_cycle", redirect, 1'b0);
    chk1 ("early_ack_ignored", pred_ready, 1'b0);
    cyc();
    flush_ack = 1'b0;
    chk1 ("ack_ready", pred_ready, 1'b1);
    chk1 ("ack_idle", busy, 1'b0);

    // Predicted taken, actually not taken: fall-through of a 32-bit instruction
    do_pair(1'b1, 32'h999, 32'h300, 1'b0, 1'b0, 32'h0);
    chk1 ("t_nt_redirect", redirect, 1'b1);
    chk32("t_nt_pc", redirect_pc, 32'h304);
    ack();

    // Taken both ways, wrong target
    do_pair(1'b1, 32'h500, 32'h10, 1'b0, 1'b1, 32'h504);
    chk1 ("tgt_redirect", redirect, 1'b1);
    chk32("tgt_pc", redirect_pc, 32'h504);

    // Resolve while in FLUSH is ignored (would otherwise flag an error)
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    cyc();
    resolve_valid = 1'b0;
    chk1 ("flush_resolve_no_err", err, 1'b0);
    chk1 ("flush_busy", busy, 1'b1);
    ack();
    chk1 ("flush_exit_ready", pred_ready, 1'b1);

    // Fill the queue
    pred_valid = 1'b1; pred_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pred_target = 32'h1000 + 32'(i * 16);
      pred_pc     = 32'h3000 + 32'(i * 4);
      cyc();
    end
    chk1 ("full_ready", pred_ready, 1'b0);
    chk1 ("full_busy", busy, 1'b1);

    // Push offered while full and popping: must be dropped
    pred_taken = 1'b0; pred_pc = 32'h7000;
    resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h1000;
    cyc();
    pred_valid = 1'b0;
    chk1 ("full_pop_no_redirect", redirect, 1'b0);
    chk1 ("after_full_pop_ready", pred_ready, 1'b1);
    for (int i = 1; i < 4; i++) begin
      resolve_target = 32'h1000 + 32'(i * 16);
      cyc();
      chk1 ("drain_no_redirect", redirect, 1'b0);
    end
    resolve_valid = 1'b0;
    chk1 ("drain_idle", busy, 1'b0);
    chk1 ("drain_no_err", err, 1'b0);

    // Fall-through wraps past 2^32 with wrapped queue pointers
    do_pair(1'b1, 32'h40, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0);
    chk1 ("wrap_redirect", redirect, 1'b1);
    chk32("wrap_pc", redirect_pc, 32'h0);
    ack();
    do_pair(1'b0, 32'h0, 32'h2000, 1'b0, 1'b0, 32'h0);
    chk1 ("wrap_pair_no_redirect", redirect, 1'b0);
    chk1 ("wrap_pair_idle", busy, 1'b0);

    // Resolve with empty queue sets a sticky error
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    cyc();
    resolve_valid = 1'b0;
    chk1 ("empty_resolve_err", err, 1'b1);
    cyc();
    chk1 ("err_sticky", err, 1'b1);

    // Asynchronous reset while in FLUSH
    do_pair(1'b1, 32'h50, 32'h60, 1'b0, 1'b0, 32'h0);
    chk1 ("pre_reset_redirect", redirect, 1'b1);
    chk32("pre_reset_pc", redirect_pc, 32'h64);
    #2 rst = 1'b1;
    #1;
    chk1 ("async_rst_redirect", redirect, 1'b0);
    chk32("async_rst_pc", redirect_pc, 32'h0);
    chk1 ("async_rst_err", err, 1'b0);
    chk1 ("async_rst_busy", busy, 1'b0);
    chk1 ("async_rst_ready", pred_ready, 1'b1);
    cyc();
    rst = 1'b0;

`ifdef IBEX_BP_PERF_EN
    chk32("perf_rst_res", perf_res, 32'd0);
    chk32("perf_rst_mis", perf_mis, 32'd0);
    for (int i = 0; i < 3; i++) do_pair(1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 32'h10);
    for (int i = 0; i < 2; i++) begin
      do_pair(1'b0, 32'h0, 32'h20, 1'b0, 1'b1, 32'h80);
      ack();
    end
    chk32("perf_res", perf_res, 32'd5);
    chk32("perf_mis", perf_mis, 32'd2);
    chk32("perf2_res_sat", {30'b0, perf2_res}, 32'd3);
    chk32("perf2_mis", {30'b0, perf2_mis}, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
